symbol_mapper: RTL and testbench

SYMBOL_MAPPER -- requirements
Module: symbol_mapper

---
 rtl/symbol_mapper.sv | 107 ++++++++++
 tb/tb_symbol_mapper.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_mapper.sv
// symbol_mapper: serial bits to BPSK/QPSK/16-QAM constellation points.
//   Ports: clk, rst (async, active-high); mode[1:0], flush, in_bit, in_valid,
//   in_ready (bit input side); out_re/out_im[DATA_W-1:0], out_valid, out_ready
//   (symbol output side). Macro SYMBOL_MAPPER_QAM16_EN builds 16-QAM support;
//   without it mode 2 maps as QPSK.
`timescale 1ns/1ps
module symbol_mapper #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              flush,
   input  logic              in_bit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              out_valid,
   input  logic              out_ready
);
`ifdef SYMBOL_MAPPER_QAM16_EN
   localparam int SW = 4;
`else
   localparam int SW = 2;
`endif
   localparam int IW = $clog2(SW);
   // Round-half-up of fraction * 2^(DATA_W-1), done in integers; the 16-bit
   // values are pinned to the reference table.
   localparam longint S  = longint'(1) << (DATA_W - 1);
   localparam longint PV = (DATA_W == 16) ? 64'sd32767 : (64'sd65534 * S + 64'sd32768) / 64'sd65536;
   localparam longint AV = (DATA_W == 16) ? 64'sd23170 : (64'sd141421356 * S + 64'sd100000000) / 64'sd200000000;
   localparam logic signed [DATA_W-1:0] P = DATA_W'(PV);
   localparam logic signed [DATA_W-1:0] A = DATA_W'(AV);
`ifdef SYMBOL_MAPPER_QAM16_EN
   localparam longint LV  = (DATA_W == 16) ? 64'sd10362 : (64'sd63245554 * S + 64'sd100000000) / 64'sd200000000;
   localparam longint L3V = (DATA_W == 16) ? 64'sd31087 : (64'sd189736660 * S + 64'sd100000000) / 64'sd200000000;
   localparam logic signed [DATA_W-1:0] L  = DATA_W'(LV);
   localparam logic signed [DATA_W-1:0] L3 = DATA_W'(L3V);
`endif

   logic [1:0]               r_cnt, r_mode, w_mode, w_k1;
   logic [SW-1:0]            r_sh, w_bits;
   logic                     w_acc, w_last, w_load;
   logic signed [DATA_W-1:0] w_re, w_im;

   assign in_ready = ~(out_valid & ~out_ready);
   assign w_acc    = in_valid & in_ready;
   // Mode is taken live on the first bit of a group, then held for the rest.
`ifdef SYMBOL_MAPPER_QAM16_EN
   assign w_mode = (r_cnt != 2'd0) ? r_mode : (mode == 2'd3) ? 2'd1 : mode;
`else
   assign w_mode = (r_cnt != 2'd0) ? r_mode : (mode == 2'd0) ? 2'd0 : 2'd1;
`endif
   assign w_k1   = (w_mode == 2'd0) ? 2'd0 : (w_mode == 2'd2) ? 2'd3 : 2'd1;
   assign w_last = (r_cnt == w_k1);
   assign w_load = w_acc & ~flush & w_last;

   // Group bits including the one arriving now, b0 = first received.
   always_comb begin
      w_bits = r_sh;
      w_bits[r_cnt[IW-1:0]] = in_bit;
   end

   always_comb begin
      w_re = w_bits[0] ? P : -P;
      w_im = '0;
      if (w_mode == 2'd1) begin
         w_re = w_bits[0] ? A : -A;
         w_im = w_bits[1] ? A : -A;
      end
`ifdef SYMBOL_MAPPER_QAM16_EN
      // Gray pairs: sign from the first bit, inner level when the second is 1.
      if (w_mode == 2'd2) begin
         w_re = w_bits[0] ? (w_bits[1] ? L : L3) : (w_bits[1] ? -L : -L3);
         w_im = w_bits[2] ? (w_bits[3] ? L : L3) : (w_bits[3] ? -L : -L3);
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_sh      <= '0;
         r_mode    <= 2'd1;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         if (flush) begin
            r_cnt <= '0;
            r_sh  <= '0;
         end else if (w_acc) begin
            r_mode <= w_mode;
            r_cnt  <= w_last ? 2'd0 : r_cnt + 2'd1;
            r_sh   <= w_last ? '0 : w_bits;
         end
         if (w_load) begin
            out_valid <= 1'b1;
            out_re    <= w_re;
            out_im    <= w_im;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_symbol_mapper.sv
// tb_symbol_mapper: randomized and directed checks against a queue-based model.
`timescale 1ns/1ps
module tb_symbol_mapper;
   localparam int P = 32767;
   localparam int A = 23170;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'd1;
   logic        flush = 1'b0, in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [15:0] out_re, out_im;

   int n_tests = 0, n_fail = 0;

   bit m_bits[$];
   int m_k = 2;
   bit m_valid = 0;
   int m_re = 0, m_im = 0;
   int lv[4] = '{-31087, -10362, 10362, 31087};

   symbol_mapper #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .mode(mode), .flush(flush), .in_bit(in_bit),
      .in_valid(in_valid), .in_ready(in_ready), .out_re(out_re), .out_im(out_im),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic int kof(input logic [1:0] md);
`ifdef SYMBOL_MAPPER_QAM16_EN
      return md == 2'd0 ? 1 : md == 2'd2 ? 4 : 2;
`else
      return md == 2'd0 ? 1 : 2;
`endif
   endfunction

   task automatic model_reset();
      m_bits.delete();
      m_k = 2;
      m_valid = 0;
      m_re = 0;
      m_im = 0;
   endtask

   task automatic model_edge();
      bit acc, ld;
      acc = in_valid && !(m_valid && !out_ready);
      ld = 0;
      if (flush) m_bits.delete();
      else if (acc) begin
         if (m_bits.size() == 0) m_k = kof(mode);
         m_bits.push_back(in_bit);
         if (m_bits.size() == m_k) begin
            ld = 1;
            if (m_k == 1) begin
               m_re = m_bits[0] ? P : -P;
               m_im = 0;
            end else if (m_k == 2) begin
               m_re = m_bits[0] ? A : -A;
               m_im = m_bits[1] ? A : -A;
            end else begin
               m_re = lv[{m_bits[0], m_bits[0] ^ m_bits[1]}];
               m_im = lv[{m_bits[2], m_bits[2] ^ m_bits[3]}];
            end
            m_bits.delete();
         end
      end
      if (ld) m_valid = 1;
      else if (out_ready) m_valid = 0;
   endtask

   task automatic drive(input logic v, b, input logic [1:0] md, input logic fl, orr);
      in_valid = v;
      in_bit = b;
      mode = md;
      flush = fl;
      out_ready = orr;
      #1;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_re !== 16'd0 || out_im !== 16'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b re=%0d im=%0d rdy=%b required 0 0 0 1", out_valid, out_re, out_im, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(0, 0, 1, 0, 0);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_cycle_ready: in_ready=%b required 1", in_ready);
      end
      tick();
   endtask

   task automatic test_qpsk();
      drive(0, 0, 1, 1, 1); tick();
      drive(1, 0, 1, 0, 1); tick();
      drive(1, 1, 1, 0, 1); tick();
      n_tests++;
      if (out_valid !== 1'b1 || $signed(out_re) !== -A || $signed(out_im) !== A) begin
         n_fail++;
         $display("FAIL qpsk_01: valid=%b re=%0d im=%0d required 1 %0d %0d", out_valid, $signed(out_re), $signed(out_im), -A, A);
      end
   endtask

   task automatic test_qam16();
      drive(0, 0, 2, 1, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
      drive(1, 0, 2, 0, 1); tick();
`ifndef SYMBOL_MAPPER_QAM16_EN
      n_tests++;
      if (out_valid !== 1'b1 || $signed(out_re) !== A || $signed(out_im) !== -A) begin
         n_fail++;
         $display("FAIL mode2_as_qpsk_first: valid=%b re=%0d im=%0d required 1 %0d %0d", out_valid, $signed(out_re), $signed(out_im), A, -A);
      end
`else
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL qam16_partial: valid=%b required 0", out_valid);
      end
`endif
      drive(1, 0, 2, 0, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
`ifdef SYMBOL_MAPPER_QAM16_EN
      n_tests++;
      if (out_valid !== 1'b1 || $signed(out_re) !== 31087 || $signed(out_im) !== -10362) begin
         n_fail++;
         $display("FAIL qam16_1001: valid=%b re=%0d im=%0d required 1 31087 -10362", out_valid, $signed(out_re), $signed(out_im));
      end
`else
      n_tests++;
      if (out_valid !== 1'b1 || $signed(out_re) !== -A || $signed(out_im) !== A) begin
         n_fail++;
         $display("FAIL mode2_as_qpsk_second: valid=%b re=%0d im=%0d required 1 %0d %0d", out_valid, $signed(out_re), $signed(out_im), -A, A);
      end
`endif
   endtask

   task automatic test_bpsk_stream();
      logic b;
      drive(0, 0, 0, 1, 1); tick();
      for (int i = 0; i < 12; i++) begin
         b = 1'($urandom_range(0, 1));
         drive(1, b, 0, 0, 1);
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || $signed(out_re) !== (b ? P : -P) || out_im !== 16'd0) begin
            n_fail++;
            $display("FAIL bpsk_stream[%0d]: valid=%b re=%0d im=%0d required 1 %0d 0", i, out_valid, $signed(out_re), $signed(out_im), b ? P : -P);
         end
      end
   endtask

   task automatic test_backpressure();
      drive(0, 0, 1, 1, 1); tick();
      drive(1, 1, 1, 0, 1); tick();
      drive(1, 0, 1, 0, 0); tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1'($urandom_range(0, 1)), 1, 0, 0);
         n_tests++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready[%0d]: in_ready=%b required 0", i, in_ready);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || $signed(out_re) !== A || $signed(out_im) !== -A) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: valid=%b re=%0d im=%0d required 1 %0d %0d", i, out_valid, $signed(out_re), $signed(out_im), A, -A);
         end
      end
      drive(1, 1, 1, 0, 1);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL release_taken: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_flush_mode();
      drive(0, 0, 1, 1, 1); tick();
      drive(1, 1, 1, 0, 1); tick();
      drive(1, 0, 0, 1, 1); tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_discard: out_valid=%b required 0", out_valid);
      end
      drive(1, 1, 0, 0, 1); tick();
      n_tests++;
      if (out_valid !== 1'b1 || $signed(out_re) !== P || out_im !== 16'd0) begin
         n_fail++;
         $display("FAIL flush_then_bpsk: valid=%b re=%0d im=%0d required 1 %0d 0", out_valid, $signed(out_re), $signed(out_im), P);
      end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 2, 1, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
      drive(1, 0, 2, 0, 1); tick();
      drive(1, 0, 2, 0, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
      drive(0, 0, 2, 0, 0); tick();
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_re !== 16'd0 || out_im !== 16'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b re=%0d im=%0d rdy=%b required 0 0 0 1", out_valid, out_re, out_im, in_ready);
      end
      model_reset();
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1, 1, 2, 0, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
      #2 rst = 1'b1;
      model_reset();
      #1 rst = 1'b0;
      drive(1, 0, 2, 0, 1); tick();
      drive(1, 0, 2, 0, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
      drive(1, 1, 2, 0, 1); tick();
      n_tests++;
      if (out_valid !== m_valid || $signed(out_re) !== m_re || $signed(out_im) !== m_im) begin
         n_fail++;
         $display("FAIL reset_discards_partial: valid=%b re=%0d im=%0d required %b %0d %0d", out_valid, $signed(out_re), $signed(out_im), m_valid, m_re, m_im);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
         n_tests++;
         if (in_ready !== !(m_valid && !out_ready)) begin
            n_fail++;
            $display("FAIL random_ready[%0d]: in_ready=%b required %b", i, in_ready, !(m_valid && !out_ready));
         end
         tick();
         n_tests++;
         if (out_valid !== m_valid || $signed(out_re) !== m_re || $signed(out_im) !== m_im) begin
            n_fail++;
            $display("FAIL random_out[%0d]: valid=%b re=%0d im=%0d required %b %0d %0d", i, out_valid, $signed(out_re), $signed(out_im), m_valid, m_re, m_im);
         end
      end
   endtask

   initial begin
      test_reset();
      test_qpsk();
      test_qam16();
      test_bpsk_stream();
      test_backpressure();
      test_flush_mode();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
